// File: rtl/snake_pkg.sv
// Shared constants for the snake game video path: screen bounds, colours and
// the plot arbiter state encoding.
package snake_pkg;

  localparam int SCREEN_X_MAX = 159;
  localparam int SCREEN_Y_MAX = 119;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAW     = 3'd1,
    ST_DONE     = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_CLR_DONE = 3'd4
  } arb_state_e;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Bundle between the game FSMs and the plot arbiter, plus the pixel write
// port the arbiter drives toward the VGA adapter.
interface vga_plot_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] x_in;
  logic [7*NUM_REQ-1:0] y_in;
  logic [3*NUM_REQ-1:0] colour_in;
  logic                 clear_req;
  logic [7:0]           x_out;
  logic [6:0]           y_out;
  logic [2:0]           colour_out;
  logic                 plot;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 clear_done;
  logic                 busy;

  modport master (
    output req, x_in, y_in, colour_in, clear_req,
    input  x_out, y_out, colour_out, plot, grant, done, clear_done, busy
  );

  modport slave (
    input  req, x_in, y_in, colour_in, clear_req,
    output x_out, y_out, colour_out, plot, grant, done, clear_done, busy
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the
// pointer, searching cyclically. Outputs one-hot winner and its index.
module rr_picker #(
  parameter int N = 3
) (
  input  logic [N-1:0]                       req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                       win_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = ptr_i;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        win_o[cand] = 1'b1;
        idx_o       = cand;
      end
      cand = (cand == IDX_W'(N - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA write port among tile requesters and a full-screen clear;
// each grant becomes a TILE x TILE burst of pixel writes with edge clipping.
module vga_plot_arbiter
  import snake_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TILE    = 2,
  parameter int X_MAX   = SCREEN_X_MAX,
  parameter int Y_MAX   = SCREEN_Y_MAX
) (
  input logic               clk,
  input logic               rst,
  vga_plot_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OFF_W = (TILE > 1) ? $clog2(TILE) : 1;

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [7:0]          xl_q, xl_d;
  logic [6:0]          yl_q, yl_d;
  logic [2:0]          col_q, col_d;
  logic [OFF_W-1:0]    dx_q, dx_d, dy_q, dy_d;
  logic [7:0]          cx_q, cx_d;
  logic [6:0]          cy_q, cy_d;

  logic [NUM_REQ-1:0]  win;
  logic [IDX_W-1:0]    win_idx;
  logic [8:0]          xs;
  logic [7:0]          ys;
  logic                in_range;

  logic [7:0]          x_o;
  logic [6:0]          y_o;
  logic [2:0]          col_o;
  logic                plot_o;
  logic [NUM_REQ-1:0]  done_o;
  logic                clr_done_o;

  rr_picker #(.N(NUM_REQ)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .win_o (win),
    .idx_o (win_idx)
  );

  // Sums carry one extra bit so a tile hanging off the right/bottom edge clips instead of wrapping.
  assign xs       = {1'b0, xl_q} + 9'(dx_q);
  assign ys       = {1'b0, yl_q} + 8'(dy_q);
  assign in_range = (xs <= 9'(X_MAX)) && (ys <= 8'(Y_MAX));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    xl_d       = xl_q;
    yl_d       = yl_q;
    col_d      = col_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    x_o        = '0;
    y_o        = '0;
    col_o      = '0;
    plot_o     = 1'b0;
    done_o     = '0;
    clr_done_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.clear_req) begin
          cx_d    = '0;
          cy_d    = '0;
          state_d = ST_CLEAR;
        end else if (|bus.req) begin
          grant_d = win;
          gidx_d  = win_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
              xl_d  = bus.x_in[8*i +: 8];
              yl_d  = bus.y_in[7*i +: 7];
              col_d = bus.colour_in[3*i +: 3];
            end
          end
          dx_d    = '0;
          dy_d    = '0;
          state_d = ST_DRAW;
        end
      end

      ST_DRAW: begin
        plot_o = in_range;
        if (in_range) begin
          x_o   = xs[7:0];
          y_o   = ys[6:0];
          col_o = col_q;
        end
        if (dx_q == OFF_W'(TILE - 1)) begin
          dx_d = '0;
          if (dy_q == OFF_W'(TILE - 1)) begin
            dy_d    = '0;
            state_d = ST_DONE;
          end else begin
            dy_d = dy_q + 1'b1;
          end
        end else begin
          dx_d = dx_q + 1'b1;
        end
      end

      ST_DONE: begin
        done_o  = grant_q;
        ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        grant_d = '0;
        state_d = ST_IDLE;
      end

      ST_CLEAR: begin
        plot_o = 1'b1;
        x_o    = cx_q;
        y_o    = cy_q;
        col_o  = BLACK;
        if (cx_q == 8'(X_MAX)) begin
          cx_d = '0;
          if (cy_q == 7'(Y_MAX)) begin
            cy_d    = '0;
            state_d = ST_CLR_DONE;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end

      ST_CLR_DONE: begin
        clr_done_o = 1'b1;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  // Tile attributes are only meaningful while DRAW is active, so they carry no reset.
  always_ff @(posedge clk) begin
    xl_q  <= xl_d;
    yl_q  <= yl_d;
    col_q <= col_d;
  end

  assign bus.x_out      = x_o;
  assign bus.y_out      = y_o;
  assign bus.colour_out = col_o;
  assign bus.plot       = plot_o;
  assign bus.grant      = grant_q;
  assign bus.done       = done_o;
  assign bus.clear_done = clr_done_o;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter at NUM_REQ=3, TILE=2, 160x120 screen.
module tb_vga_plot_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  vga_plot_arbiter_if #(.NUM_REQ(3)) bus ();

  vga_plot_arbiter #(
    .NUM_REQ (3),
    .TILE    (2),
    .X_MAX   (159),
    .Y_MAX   (119)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tile(input int i, input int x, input int y, input int c);
    bus.x_in[8*i +: 8]      = 8'(x);
    bus.y_in[7*i +: 7]      = 7'(y);
    bus.colour_in[3*i +: 3] = 3'(c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req       = '0;
    bus.clear_req = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.colour_in = '0;
    do_reset();
    checks++;
    if ({bus.busy, bus.plot, bus.grant, bus.done, bus.clear_done, bus.x_out, bus.y_out, bus.colour_out} !== 27'd0) begin
      errors++;
      $display("FAIL reset busy=%0b plot=%0b grant=%b done=%b clr=%0b x=%0d y=%0d c=%0d, want all 0",
               bus.busy, bus.plot, bus.grant, bus.done, bus.clear_done, bus.x_out, bus.y_out, bus.colour_out);
    end
  endtask

  task automatic test_single_tile();
    set_tile(1, 10, 20, 3'b010);
    bus.req = 3'b010;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({bus.plot, bus.x_out, bus.y_out, bus.colour_out, bus.grant, bus.done} !==
          {1'b1, 8'(10 + k % 2), 7'(20 + k / 2), 3'b010, 3'b010, 3'b000}) begin
        errors++;
        $display("FAIL single_plot%0d got plot=%0b (%0d,%0d) c=%b g=%b d=%b, want 1 (%0d,%0d) 010 010 000",
                 k, bus.plot, bus.x_out, bus.y_out, bus.colour_out, bus.grant, bus.done, 10 + k % 2, 20 + k / 2);
      end
    end
    step();
    checks++;
    if ({bus.done, bus.grant, bus.plot, bus.busy} !== {3'b010, 3'b010, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_done got done=%b grant=%b plot=%0b busy=%0b, want 010 010 0 1",
               bus.done, bus.grant, bus.plot, bus.busy);
    end
    bus.req = 3'b000;
    step();
    checks++;
    if ({bus.busy, bus.grant, bus.done} !== 7'd0) begin
      errors++;
      $display("FAIL single_idle got busy=%0b grant=%b done=%b, want 0 000 000", bus.busy, bus.grant, bus.done);
    end
  endtask

  task automatic test_input_hold();
    set_tile(0, 50, 60, 3'b111);
    bus.req = 3'b001;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) set_tile(0, 100, 5, 3'b001);
      checks++;
      if ({bus.plot, bus.x_out, bus.y_out, bus.colour_out} !== {1'b1, 8'(50 + k % 2), 7'(60 + k / 2), 3'b111}) begin
        errors++;
        $display("FAIL hold_plot%0d got plot=%0b (%0d,%0d) c=%b, want 1 (%0d,%0d) 111",
                 k, bus.plot, bus.x_out, bus.y_out, bus.colour_out, 50 + k % 2, 60 + k / 2);
      end
    end
    step();
    checks++;
    if (bus.done !== 3'b001) begin
      errors++;
      $display("FAIL hold_done got %b want 001", bus.done);
    end
    bus.req = 3'b000;
    step();
  endtask

  task automatic test_clip();
    logic [3:0] exp_plot;
    int         tx, ty;
    for (int t = 0; t < 2; t++) begin
      tx       = (t == 0) ? 159 : 255;
      ty       = (t == 0) ? 119 : 0;
      exp_plot = (t == 0) ? 4'b0001 : 4'b0000;
      set_tile(0, tx, ty, 3'b100);
      bus.req = 3'b001;
      for (int k = 0; k < 4; k++) begin
        step();
        checks++;
        if ({bus.plot, bus.x_out, bus.y_out} !==
            (exp_plot[k] ? {1'b1, 8'(tx + k % 2), 7'(ty + k / 2)} : 16'd0)) begin
          errors++;
          $display("FAIL clip%0d_cyc%0d got plot=%0b (%0d,%0d), want plot=%0b",
                   t, k, bus.plot, bus.x_out, bus.y_out, exp_plot[k]);
        end
      end
      step();
      checks++;
      if ({bus.done, bus.busy} !== {3'b001, 1'b1}) begin
        errors++;
        $display("FAIL clip%0d_done got done=%b busy=%0b, want 001 1", t, bus.done, bus.busy);
      end
      bus.req = 3'b000;
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    do_reset();
    set_tile(0, 0, 0, 3'b001);
    set_tile(1, 20, 0, 3'b010);
    set_tile(2, 40, 0, 3'b100);
    for (int pass = 0; pass < 2; pass++) begin
      bus.req = 3'b111;
      for (int n = 0; n < 3; n++) begin
        exp_g = 3'(1 << n);
        step();
        checks++;
        if ({bus.grant, bus.x_out} !== {exp_g, 8'(20 * n)}) begin
          errors++;
          $display("FAIL rr_grant p%0d n%0d got grant=%b x=%0d, want %b x=%0d",
                   pass, n, bus.grant, bus.x_out, exp_g, 20 * n);
        end
        step();
        step();
        step();
        step();
        checks++;
        if (bus.done !== exp_g) begin
          errors++;
          $display("FAIL rr_done p%0d n%0d got %b want %b", pass, n, bus.done, exp_g);
        end
        bus.req[n] = 1'b0;
        step();
      end
    end
  endtask

  task automatic test_clear_vs_tile();
    int n    = 0;
    int bad  = 0;
    int lx   = -1;
    int ly   = -1;
    bit seen = 1'b0;
    set_tile(0, 30, 40, 3'b100);
    bus.req       = 3'b001;
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    checks++;
    if ({bus.busy, bus.plot, bus.grant, bus.x_out, bus.y_out, bus.colour_out} !== {1'b1, 1'b1, 21'd0}) begin
      errors++;
      $display("FAIL clear_start got busy=%0b plot=%0b grant=%b (%0d,%0d) c=%b, want 1 1 000 (0,0) 000",
               bus.busy, bus.plot, bus.grant, bus.x_out, bus.y_out, bus.colour_out);
    end
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (bus.clear_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.plot === 1'b1) begin
          n++;
          lx = bus.x_out;
          ly = bus.y_out;
          if (bus.colour_out !== 3'b000) bad++;
        end
        if (bus.grant !== 3'b000 || bus.done !== 3'b000) bad++;
        step();
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL clear_done_seen got none within 20000 cycles, want a pulse");
    end
    checks++;
    if (n != 19200) begin
      errors++;
      $display("FAIL clear_count got %0d plots want 19200", n);
    end
    checks++;
    if (lx != 159 || ly != 119) begin
      errors++;
      $display("FAIL clear_last got (%0d,%0d) want (159,119)", lx, ly);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_clean got %0d bad cycles want 0", bad);
    end
    step();
    checks++;
    if ({bus.busy, bus.clear_done, bus.grant} !== 5'd0) begin
      errors++;
      $display("FAIL clear_idle got busy=%0b clr=%0b grant=%b, want 0 0 000", bus.busy, bus.clear_done, bus.grant);
    end
    step();
    checks++;
    if ({bus.grant, bus.plot, bus.x_out, bus.y_out, bus.colour_out} !== {3'b001, 1'b1, 8'd30, 7'd40, 3'b100}) begin
      errors++;
      $display("FAIL clear_then_tile got grant=%b plot=%0b (%0d,%0d) c=%b, want 001 1 (30,40) 100",
               bus.grant, bus.plot, bus.x_out, bus.y_out, bus.colour_out);
    end
    step();
    step();
    step();
    step();
    checks++;
    if (bus.done !== 3'b001) begin
      errors++;
      $display("FAIL clear_tile_done got %b want 001", bus.done);
    end
    bus.req = 3'b000;
    step();
  endtask

  task automatic test_reset_mid_tile();
    set_tile(2, 70, 80, 3'b111);
    bus.req = 3'b100;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.plot, bus.grant, bus.done} !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid got busy=%0b plot=%0b grant=%b done=%b, want 0 0 000 000",
               bus.busy, bus.plot, bus.grant, bus.done);
    end
    step();
    checks++;
    if ({bus.grant, bus.plot, bus.x_out, bus.y_out, bus.done} !== {3'b100, 1'b1, 8'd70, 7'd80, 3'b000}) begin
      errors++;
      $display("FAIL rst_regrant got grant=%b plot=%0b (%0d,%0d) done=%b, want 100 1 (70,80) 000",
               bus.grant, bus.plot, bus.x_out, bus.y_out, bus.done);
    end
    step();
    step();
    step();
    step();
    checks++;
    if (bus.done !== 3'b100) begin
      errors++;
      $display("FAIL rst_regrant_done got %b want 100", bus.done);
    end
    bus.req = 3'b000;
    step();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_tile();
    test_input_hold();
    test_clip();
    test_round_robin();
    test_clear_vs_tile();
    test_reset_mid_tile();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
